hazard_stall_ctrl: RTL and testbench
====================================

# hazard_stall_ctrl

Central stall/flush controller for the 5-stage RISC-V pipeline. It decides each cycle whether each pipeline register advances, holds, takes a bubble or is flushed. Inputs are load-use hazards, taken branches resolved in ID, a multi-cycle multiplier occupying EX, and data-memory stalls. It sits beside the EX-stage forwarding unit and drives the write-enable and bubble inputs of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.

## Interface
- MUL_LAT, 4, total EX-occupancy cycles of a mul instruction; legal range 2..16
- CNT_W, 16, width of the stall-cycle performance counter
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-low reset
- IDRS1addr_i / IDRS2addr_i  in  5 each  source registers of the instruction in ID
- EXMemRead_i  in  1  instruction in EX is a load
- EXRDaddr_i  in  5  destination register of the instruction in EX
- EXMul_i  in  1  instruction in EX is a multi-cycle mul
- Branch_i  in  1  branch in ID resolved taken this cycle
- MemStall_i  in  1  data memory not ready this cycle
- PCWrite_o, IFIDWrite_o, IDEXWrite_o, EXMEMWrite_o, MEMWBWrite_o  out  1 each  register advance enables
- IFIDFlush_o  out  1  zero IF/ID instruction
- IDEXBubble_o  out  1  zero ID/EX control fields
- EXMEMBubble_o  out  1  zero EX/MEM control fields
- mulBusy_o  out  1  FSM in MUL state
- stallCycles_o  out  CNT_W  saturating count of cycles with PCWrite_o=0

## Operation
- FSM states: RUN, MUL. Register mulCnt holds log2(MUL_LAT) bits.
- The conditions below are evaluated in priority order. The first match wins, and all outputs not listed default to enables=1, bubbles/flush=0.
- 1. MemStall_i=1: all five enables=0, no bubble/flush. State and mulCnt hold.
- 2. Mul stall, either RUN&EXMul_i or MUL&mulCnt≠0:
  - PC, IF/ID and ID/EX enables=0. EXMEMBubble_o=1.
  - In RUN: next state MUL, mulCnt←MUL_LAT-2.
  - In MUL: mulCnt←mulCnt-1.
  - Branch_i is ignored.
- 3. MUL&mulCnt=0: mul completes, pipeline advances normally, next state RUN. Branch and load-use rules 4–5 still apply this cycle.
- 4. Load-use: EXMemRead_i & EXRDaddr_i≠0 & (EXRDaddr_i==IDRS1addr_i | EXRDaddr_i==IDRS2addr_i).
  - PCWrite_o=0, IFIDWrite_o=0, IDEXBubble_o=1.
  - IFIDFlush_o=0 even if Branch_i=1; the branch re-resolves next cycle.
- 5. Branch_i=1 with no stall: IFIDFlush_o=1.
- stallCycles_o increments when PCWrite_o=0 and saturates at all-ones.

## Timing
- All outputs are combinational from the current state/count and inputs. State, mulCnt and counter update on the rising clk_i edge.
- Reset, while rst_i=0:
  - Outputs: all enables=1, IFIDFlush_o/IDEXBubble_o/EXMEMBubble_o=0, mulBusy_o=0, stallCycles_o=0.
  - Next state RUN, mulCnt=0.
  - Reset asserted mid-MUL aborts the sequence. The first cycle after reset is RUN.
- Mul occupies EX for exactly MUL_LAT cycles: MUL_LAT-1 stall cycles, then one advance cycle. MUL_LAT=2 gives one stall cycle.
- MemStall_i during MUL freezes mulCnt, so total EX occupancy = MUL_LAT + number of MemStall cycles.
- A back-to-back mul in the cycle after completion re-enters MUL from RUN.
- A load-use stall lasts exactly one cycle unless MemStall_i extends it (hold, no bubble).

## Structure
- Shared package:
  - FSM state encoding (RUN=1'b0, MUL=1'b1).
  - MUL_LAT default.
  - A typedef bundling the eight pipeline control outputs, reused by the pipeline top.
- One sub-module, load_use_detect: combinational comparator producing the load-use condition, including the rd≠0 check.
- FSM, counter and priority mux stay in hazard_stall_ctrl.

## Test plan
- Load-use: EXMemRead_i=1, EXRDaddr_i=5, IDRS2addr_i=5 for one cycle -> PCWrite_o=IFIDWrite_o=0, IDEXBubble_o=1 that cycle only; stallCycles_o=1. Same stimulus with EXRDaddr_i=0 -> no stall.
- Mul, MUL_LAT=4: EXMul_i=1 at cycle t -> EXMEMBubble_o=1 and PCWrite_o=0 at t, t+1, t+2; all enables=1 at t+3; mulBusy_o=1 at t+1..t+3.
- MemStall_i=1 at t+1 of the mul sequence -> all enables=0 at t+1; mul advance moves from t+3 to t+4.
- Branch_i=1 alone -> IFIDFlush_o=1. Branch_i=1 with a simultaneous load-use hazard -> IFIDFlush_o=0 and the stall asserts. Branch_i=1 during a mul stall -> IFIDFlush_o=0.
- rst_i=0 at t+1 of a mul sequence -> next cycle RUN, mulBusy_o=0, stallCycles_o=0, all enables=1.
- Counter saturation with CNT_W=4: 20 consecutive MemStall cycles -> stallCycles_o=15 and holds there.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// The pipeline top reuses pipe_ctrl_t to route enables and bubbles.
package hazard_stall_ctrl_pkg;

    localparam int unsigned MulLatDefault = 4;
    localparam int unsigned RegAddrW      = 5;

    typedef enum logic {
        StRun = 1'b0,
        StMul = 1'b1
    } hsc_state_e;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_write;
        logic exmem_write;
        logic memwb_write;
        logic ifid_flush;
        logic idex_bubble;
        logic exmem_bubble;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t PipeCtrlAdvance = '{
        pc_write:     1'b1,
        ifid_write:   1'b1,
        idex_write:   1'b1,
        exmem_write:  1'b1,
        memwb_write:  1'b1,
        ifid_flush:   1'b0,
        idex_bubble:  1'b0,
        exmem_bubble: 1'b0
    };

endpackage

// File: rtl/load_use_detect.sv
// Flags a load in EX whose destination feeds a source of the instruction in ID.
// Writes to x0 never create a dependency.
module load_use_detect
    import hazard_stall_ctrl_pkg::*;
(
    input  logic                ex_mem_read_i,
    input  logic [RegAddrW-1:0] ex_rd_addr_i,
    input  logic [RegAddrW-1:0] id_rs1_addr_i,
    input  logic [RegAddrW-1:0] id_rs2_addr_i,
    output logic                load_use_o
);

    logic rd_nonzero;
    logic rs_match;

    assign rd_nonzero = (ex_rd_addr_i != '0);
    assign rs_match   = (ex_rd_addr_i == id_rs1_addr_i) || (ex_rd_addr_i == id_rs2_addr_i);
    assign load_use_o = ex_mem_read_i && rd_nonzero && rs_match;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Central stall/flush controller: memory stall > mul stall > load-use > branch flush.
// Outputs are combinational; FSM, mul counter and stall counter are clocked.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = MulLatDefault,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [RegAddrW-1:0] IDRS1addr_i,
    input  logic [RegAddrW-1:0] IDRS2addr_i,
    input  logic                EXMemRead_i,
    input  logic [RegAddrW-1:0] EXRDaddr_i,
    input  logic                EXMul_i,
    input  logic                Branch_i,
    input  logic                MemStall_i,
    output logic                PCWrite_o,
    output logic                IFIDWrite_o,
    output logic                IDEXWrite_o,
    output logic                EXMEMWrite_o,
    output logic                MEMWBWrite_o,
    output logic                IFIDFlush_o,
    output logic                IDEXBubble_o,
    output logic                EXMEMBubble_o,
    output logic                mulBusy_o,
    output logic [CNT_W-1:0]    stallCycles_o
);

    localparam int unsigned        MulCntW    = $clog2(MUL_LAT);
    localparam logic [MulCntW-1:0] MulCntInit = MulCntW'(MUL_LAT - 2);
    localparam logic [MulCntW-1:0] MulCntOne  = MulCntW'(1);
    localparam logic [CNT_W-1:0]   StallOne   = CNT_W'(1);

    hsc_state_e         state_q, state_d;
    logic [MulCntW-1:0] mul_cnt_q, mul_cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q;
    pipe_ctrl_t         ctrl;
    logic               load_use;
    logic               mul_stall;

    load_use_detect u_load_use_detect (
        .ex_mem_read_i (EXMemRead_i),
        .ex_rd_addr_i  (EXRDaddr_i),
        .id_rs1_addr_i (IDRS1addr_i),
        .id_rs2_addr_i (IDRS2addr_i),
        .load_use_o    (load_use)
    );

    assign mul_stall = ((state_q == StRun) && EXMul_i) ||
                       ((state_q == StMul) && (mul_cnt_q != '0));

    always_comb begin
        ctrl      = PipeCtrlAdvance;
        state_d   = state_q;
        mul_cnt_d = mul_cnt_q;
        if (MemStall_i) begin
            ctrl.pc_write    = 1'b0;
            ctrl.ifid_write  = 1'b0;
            ctrl.idex_write  = 1'b0;
            ctrl.exmem_write = 1'b0;
            ctrl.memwb_write = 1'b0;
        end else if (mul_stall) begin
            ctrl.pc_write     = 1'b0;
            ctrl.ifid_write   = 1'b0;
            ctrl.idex_write   = 1'b0;
            ctrl.exmem_bubble = 1'b1;
            state_d           = StMul;
            mul_cnt_d         = (state_q == StRun) ? MulCntInit : (mul_cnt_q - MulCntOne);
        end else begin
            // Completion cycle of a mul still honours load-use and branch below.
            state_d = StRun;
            if (load_use) begin
                ctrl.pc_write    = 1'b0;
                ctrl.ifid_write  = 1'b0;
                ctrl.idex_bubble = 1'b1;
            end else if (Branch_i) begin
                ctrl.ifid_flush = 1'b1;
            end
        end
        if (!rst_i) begin
            ctrl      = PipeCtrlAdvance;
            state_d   = StRun;
            mul_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= StRun;
            mul_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
            if (!ctrl.pc_write && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + StallOne;
            end
        end
    end

    assign PCWrite_o     = ctrl.pc_write;
    assign IFIDWrite_o   = ctrl.ifid_write;
    assign IDEXWrite_o   = ctrl.idex_write;
    assign EXMEMWrite_o  = ctrl.exmem_write;
    assign MEMWBWrite_o  = ctrl.memwb_write;
    assign IFIDFlush_o   = ctrl.ifid_flush;
    assign IDEXBubble_o  = ctrl.idex_bubble;
    assign EXMEMBubble_o = ctrl.exmem_bubble;
    assign mulBusy_o     = rst_i && (state_q == StMul);
    assign stallCycles_o = rst_i ? stall_cnt_q : '0;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scenario bench for hazard_stall_ctrl: expected per-cycle controls are queued
// when stimulus is applied and compared when the cycle is sampled.
module tb_hazard_stall_ctrl;

    localparam int unsigned MUL_LAT = 4;
    localparam int unsigned CNT_W   = 4;

    // {pc, ifid, idex, exmem, memwb, flush, idex_bubble, exmem_bubble}
    localparam logic [7:0] NORM  = 8'b11111_000;
    localparam logic [7:0] MEMST = 8'b00000_000;
    localparam logic [7:0] MULST = 8'b00011_001;
    localparam logic [7:0] LU    = 8'b00111_010;
    localparam logic [7:0] BR    = 8'b11111_100;

    typedef struct packed {
        logic       mr;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       mul;
        logic       br;
        logic       ms;
        logic       rst;
    } stim_t;

    typedef struct {
        string            name;
        logic [7:0]       ctrl;
        logic             busy;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk;
    logic rst;
    logic [4:0] rs1, rs2, rd;
    logic mem_read, mul, branch, mem_stall;
    logic pc_w, ifid_w, idex_w, exmem_w, memwb_w, ifid_flush, idex_bub, exmem_bub, busy;
    logic [CNT_W-1:0] stall_cycles;

    exp_t             sb[$];
    logic [CNT_W-1:0] exp_cnt;
    int               n_tests;
    int               n_fail;

    hazard_stall_ctrl #(
        .MUL_LAT (MUL_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .IDRS1addr_i   (rs1),
        .IDRS2addr_i   (rs2),
        .EXMemRead_i   (mem_read),
        .EXRDaddr_i    (rd),
        .EXMul_i       (mul),
        .Branch_i      (branch),
        .MemStall_i    (mem_stall),
        .PCWrite_o     (pc_w),
        .IFIDWrite_o   (ifid_w),
        .IDEXWrite_o   (idex_w),
        .EXMEMWrite_o  (exmem_w),
        .MEMWBWrite_o  (memwb_w),
        .IFIDFlush_o   (ifid_flush),
        .IDEXBubble_o  (idex_bub),
        .EXMEMBubble_o (exmem_bub),
        .mulBusy_o     (busy),
        .stallCycles_o (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t st(input logic mr_a, input logic [4:0] rd_a, input logic [4:0] rs1_a,
                                 input logic [4:0] rs2_a, input logic mul_a, input logic br_a,
                                 input logic ms_a, input logic rst_a);
        stim_t s;
        s.mr = mr_a; s.rd = rd_a; s.rs1 = rs1_a; s.rs2 = rs2_a;
        s.mul = mul_a; s.br = br_a; s.ms = ms_a; s.rst = rst_a;
        return s;
    endfunction

    function automatic stim_t idle();
        return st(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endfunction

    function automatic stim_t mul_op(input logic br_a, input logic ms_a, input logic rst_a);
        return st(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, br_a, ms_a, rst_a);
    endfunction

    function automatic logic [12:0] observed();
        return {pc_w, ifid_w, idex_w, exmem_w, memwb_w, ifid_flush, idex_bub, exmem_bub,
                busy, stall_cycles};
    endfunction

    // Applies one cycle of stimulus and queues what that cycle must show.
    task automatic drive(input string name, input stim_t s, input logic [8:0] e);
        exp_t x;
        @(posedge clk);
        #1;
        mem_read = s.mr; rd = s.rd; rs1 = s.rs1; rs2 = s.rs2;
        mul = s.mul; branch = s.br; mem_stall = s.ms; rst = s.rst;
        x.name = name;
        x.ctrl = e[8:1];
        x.busy = e[0];
        x.cnt  = s.rst ? exp_cnt : '0;
        sb.push_back(x);
        if (!s.rst) exp_cnt = '0;
        else if (!e[8] && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic test_reset();
        stim_t s[$]; logic [8:0] e[$]; exp_t x; logic [12:0] obs;
        s.push_back(mul_op(1'b1, 1'b1, 1'b0));             e.push_back({NORM, 1'b0});
        s.push_back(st(1, 5'd5, 5'd5, 5'd5, 0, 0, 0, 0));  e.push_back({NORM, 1'b0});
        s.push_back(idle());                               e.push_back({NORM, 1'b0});
        foreach (s[i]) begin
            drive("reset", s[i], e[i]);
            @(negedge clk);
            x = sb.pop_front(); obs = observed(); n_tests++;
            if (obs !== {x.ctrl, x.busy, x.cnt}) begin
                n_fail++;
                $display("FAIL %s step %0d: got ctrl=%b busy=%b cnt=%0d, expected ctrl=%b busy=%b cnt=%0d",
                         x.name, i, obs[12:5], obs[4], obs[3:0], x.ctrl, x.busy, x.cnt);
            end
        end
    endtask

    task automatic test_load_use();
        stim_t s[$]; logic [8:0] e[$]; exp_t x; logic [12:0] obs;
        s.push_back(st(1, 5'd5, 5'd0, 5'd5, 0, 0, 0, 1));  e.push_back({LU, 1'b0});
        s.push_back(idle());                               e.push_back({NORM, 1'b0});
        s.push_back(st(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1));  e.push_back({NORM, 1'b0});
        s.push_back(st(1, 5'd7, 5'd7, 5'd3, 0, 0, 0, 1));  e.push_back({LU, 1'b0});
        s.push_back(st(0, 5'd7, 5'd7, 5'd7, 0, 0, 0, 1));  e.push_back({NORM, 1'b0});
        s.push_back(st(1, 5'd9, 5'd9, 5'd9, 0, 1, 0, 1));  e.push_back({LU, 1'b0});
        s.push_back(idle());                               e.push_back({NORM, 1'b0});
        foreach (s[i]) begin
            drive("load_use", s[i], e[i]);
            @(negedge clk);
            x = sb.pop_front(); obs = observed(); n_tests++;
            if (obs !== {x.ctrl, x.busy, x.cnt}) begin
                n_fail++;
                $display("FAIL %s step %0d: got ctrl=%b busy=%b cnt=%0d, expected ctrl=%b busy=%b cnt=%0d",
                         x.name, i, obs[12:5], obs[4], obs[3:0], x.ctrl, x.busy, x.cnt);
            end
        end
    endtask

    task automatic test_mul();
        stim_t s[$]; logic [8:0] e[$]; exp_t x; logic [12:0] obs;
        s.push_back(mul_op(1'b0, 1'b0, 1'b1));  e.push_back({MULST, 1'b0});
        s.push_back(mul_op(1'b0, 1'b0, 1'b1));  e.push_back({MULST, 1'b1});
        s.push_back(mul_op(1'b1, 1'b0, 1'b1));  e.push_back({MULST, 1'b1});
        s.push_back(mul_op(1'b1, 1'b0, 1'b1));  e.push_back({BR, 1'b1});
        s.push_back(idle());                    e.push_back({NORM, 1'b0});
        foreach (s[i]) begin
            drive("mul", s[i], e[i]);
            @(negedge clk);
            x = sb.pop_front(); obs = observed(); n_tests++;
            if (obs !== {x.ctrl, x.busy, x.cnt}) begin
                n_fail++;
                $display("FAIL %s step %0d: got ctrl=%b busy=%b cnt=%0d, expected ctrl=%b busy=%b cnt=%0d",
                         x.name, i, obs[12:5], obs[4], obs[3:0], x.ctrl, x.busy, x.cnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t s[$]; logic [8:0] e[$]; exp_t x; logic [12:0] obs;
        s.push_back(mul_op(1'b0, 1'b0, 1'b1));  e.push_back({MULST, 1'b0});
        s.push_back(mul_op(1'b0, 1'b1, 1'b1));  e.push_back({MEMST, 1'b1});
        s.push_back(mul_op(1'b0, 1'b0, 1'b1));  e.push_back({MULST, 1'b1});
        s.push_back(mul_op(1'b0, 1'b0, 1'b1));  e.push_back({MULST, 1'b1});
        s.push_back(mul_op(1'b0, 1'b0, 1'b1));  e.push_back({NORM, 1'b1});
        s.push_back(mul_op(1'b0, 1'b0, 1'b1));  e.push_back({MULST, 1'b0});
        s.push_back(mul_op(1'b0, 1'b0, 1'b1));  e.push_back({MULST, 1'b1});
        s.push_back(mul_op(1'b0, 1'b0, 1'b1));  e.push_back({MULST, 1'b1});
        s.push_back(mul_op(1'b0, 1'b0, 1'b1));  e.push_back({NORM, 1'b1});
        s.push_back(idle());                    e.push_back({NORM, 1'b0});
        foreach (s[i]) begin
            drive("mul_memstall_b2b", s[i], e[i]);
            @(negedge clk);
            x = sb.pop_front(); obs = observed(); n_tests++;
            if (obs !== {x.ctrl, x.busy, x.cnt}) begin
                n_fail++;
                $display("FAIL %s step %0d: got ctrl=%b busy=%b cnt=%0d, expected ctrl=%b busy=%b cnt=%0d",
                         x.name, i, obs[12:5], obs[4], obs[3:0], x.ctrl, x.busy, x.cnt);
            end
        end
    endtask

    task automatic test_branch();
        stim_t s[$]; logic [8:0] e[$]; exp_t x; logic [12:0] obs;
        s.push_back(st(0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1));  e.push_back({BR, 1'b0});
        s.push_back(st(0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 1));  e.push_back({MEMST, 1'b0});
        s.push_back(st(1, 5'd3, 5'd3, 5'd0, 0, 1, 1, 1));  e.push_back({MEMST, 1'b0});
        s.push_back(st(1, 5'd3, 5'd3, 5'd0, 0, 1, 0, 1));  e.push_back({LU, 1'b0});
        s.push_back(st(0, 5'd3, 5'd3, 5'd0, 0, 1, 0, 1));  e.push_back({BR, 1'b0});
        s.push_back(idle());                               e.push_back({NORM, 1'b0});
        foreach (s[i]) begin
            drive("branch", s[i], e[i]);
            @(negedge clk);
            x = sb.pop_front(); obs = observed(); n_tests++;
            if (obs !== {x.ctrl, x.busy, x.cnt}) begin
                n_fail++;
                $display("FAIL %s step %0d: got ctrl=%b busy=%b cnt=%0d, expected ctrl=%b busy=%b cnt=%0d",
                         x.name, i, obs[12:5], obs[4], obs[3:0], x.ctrl, x.busy, x.cnt);
            end
        end
    endtask

    task automatic test_reset_mid_mul();
        stim_t s[$]; logic [8:0] e[$]; exp_t x; logic [12:0] obs;
        s.push_back(mul_op(1'b0, 1'b0, 1'b1));  e.push_back({MULST, 1'b0});
        s.push_back(mul_op(1'b0, 1'b0, 1'b0));  e.push_back({NORM, 1'b0});
        s.push_back(idle());                    e.push_back({NORM, 1'b0});
        s.push_back(mul_op(1'b0, 1'b0, 1'b1));  e.push_back({MULST, 1'b0});
        s.push_back(mul_op(1'b0, 1'b0, 1'b1));  e.push_back({MULST, 1'b1});
        s.push_back(mul_op(1'b0, 1'b0, 1'b1));  e.push_back({MULST, 1'b1});
        s.push_back(mul_op(1'b0, 1'b0, 1'b1));  e.push_back({NORM, 1'b1});
        s.push_back(idle());                    e.push_back({NORM, 1'b0});
        foreach (s[i]) begin
            drive("reset_mid_mul", s[i], e[i]);
            @(negedge clk);
            x = sb.pop_front(); obs = observed(); n_tests++;
            if (obs !== {x.ctrl, x.busy, x.cnt}) begin
                n_fail++;
                $display("FAIL %s step %0d: got ctrl=%b busy=%b cnt=%0d, expected ctrl=%b busy=%b cnt=%0d",
                         x.name, i, obs[12:5], obs[4], obs[3:0], x.ctrl, x.busy, x.cnt);
            end
        end
    endtask

    task automatic test_saturation();
        stim_t s[$]; logic [8:0] e[$]; exp_t x; logic [12:0] obs;
        s.push_back(st(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0));  e.push_back({NORM, 1'b0});
        for (int k = 0; k < 20; k++) begin
            s.push_back(st(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1));
            e.push_back({MEMST, 1'b0});
        end
        s.push_back(idle());                               e.push_back({NORM, 1'b0});
        s.push_back(idle());                               e.push_back({NORM, 1'b0});
        foreach (s[i]) begin
            drive("saturation", s[i], e[i]);
            @(negedge clk);
            x = sb.pop_front(); obs = observed(); n_tests++;
            if (obs !== {x.ctrl, x.busy, x.cnt}) begin
                n_fail++;
                $display("FAIL %s step %0d: got ctrl=%b busy=%b cnt=%0d, expected ctrl=%b busy=%b cnt=%0d",
                         x.name, i, obs[12:5], obs[4], obs[3:0], x.ctrl, x.busy, x.cnt);
            end
        end
        n_tests++;
        if (stall_cycles !== 4'd15) begin
            n_fail++;
            $display("FAIL saturation_hold: got cnt=%0d, expected cnt=15", stall_cycles);
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        exp_cnt   = '0;
        rst       = 1'b0;
        mem_read  = 1'b0;
        rd        = '0;
        rs1       = '0;
        rs2       = '0;
        mul       = 1'b0;
        branch    = 1'b0;
        mem_stall = 1'b0;
        test_reset();
        test_load_use();
        test_mul();
        test_back_to_back();
        test_branch();
        test_reset_mid_mul();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
